// File: rtl/rblwe_pkg.sv
// Shared RBLWE constants and control-state encoding for the encryptor and decryptor.
package rblwe_pkg;

  localparam int unsigned N     = 256;
  localparam int unsigned W     = 8;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [W-1:0] MSG_SCALE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    OUT
  } state_t;

endpackage

// File: rtl/rblwe_negacyclic_mac.sv
// One negacyclic multiply-accumulate step: acc +/- coef when the e1 bit is set.
module rblwe_negacyclic_mac #(
  parameter int unsigned W = rblwe_pkg::W
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] coef_i,
  input  logic         e1_i,
  input  logic         wrap_i,
  input  logic         first_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] term;

  always_comb begin
    term = '0;
    if (e1_i) begin
      term = wrap_i ? ('0 - coef_i) : coef_i;
    end
    // the first outer pass overwrites, so stale accumulator contents never leak in
    acc_o = first_i ? term : (acc_i + term);
  end

endmodule

// File: rtl/rblwe_encrypt.sv
// RBLWE encryption core: c1 = a*e1 + e2, c2 = p*e1 + e3 + m*q/2 over Z_q[x]/(x^N+1).
module rblwe_encrypt #(
  parameter int unsigned N = rblwe_pkg::N,
  parameter int unsigned W = rblwe_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] p_in,
  input  logic         e1_in,
  input  logic         e2_in,
  input  logic         e3_in,
  input  logic         m_in,
  input  logic         start,
  output logic [W-1:0] c1_out,
  output logic [W-1:0] c2_out,
  output logic         valid,
  output logic         busy
);
  import rblwe_pkg::*;

  localparam int unsigned IW = $clog2(N);
  localparam logic [W-1:0]  SCALE = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] ONE   = IW'(1);
  localparam logic [IW:0]   K_END = (IW + 1)'(N + 1);
  localparam logic [IW:0]   K_ONE = (IW + 1)'(1);

  logic [W-1:0] a_mem    [N];
  logic [W-1:0] p_mem    [N];
  logic         e1_mem   [N];
  logic         e2_mem   [N];
  logic         e3_mem   [N];
  logic         m_mem    [N];
  logic [W-1:0] acc1_mem [N];
  logic [W-1:0] acc2_mem [N];

  state_t       state_q;
  logic [IW-1:0] ld_idx_q, i_q, j_q;
  logic [IW:0]  k_q;
  logic         valid_q, busy_q, rv_q;
  logic [W-1:0] c1_q, c2_q, rd1_q, rd2_q;
  logic         e2r_q, e3r_q, mr_q;

  logic [IW:0]   sum_ij;
  logic [IW-1:0] tgt;
  logic          wrap;
  logic [W-1:0]  mac1_d, mac2_d;

  // N is a power of two, so the carry out of i+j is exactly the i+j >= N wrap
  assign sum_ij = {1'b0, i_q} + {1'b0, j_q};
  assign tgt    = sum_ij[IW-1:0];
  assign wrap   = sum_ij[IW];

  rblwe_negacyclic_mac #(.W(W)) u_mac1 (
    .acc_i(acc1_mem[tgt]), .coef_i(a_mem[i_q]), .e1_i(e1_mem[j_q]),
    .wrap_i(wrap), .first_i(j_q == '0), .acc_o(mac1_d)
  );

  rblwe_negacyclic_mac #(.W(W)) u_mac2 (
    .acc_i(acc2_mem[tgt]), .coef_i(p_mem[i_q]), .e1_i(e1_mem[j_q]),
    .wrap_i(wrap), .first_i(j_q == '0), .acc_o(mac2_d)
  );

  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && load) begin
      a_mem[ld_idx_q]  <= a_in;
      p_mem[ld_idx_q]  <= p_in;
      e1_mem[ld_idx_q] <= e1_in;
      e2_mem[ld_idx_q] <= e2_in;
      e3_mem[ld_idx_q] <= e3_in;
      m_mem[ld_idx_q]  <= m_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == MULT) begin
      acc1_mem[tgt] <= mac1_d;
      acc2_mem[tgt] <= mac2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      c1_q     <= '0;
      c2_q     <= '0;
      ld_idx_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          rv_q    <= 1'b0;
          if (load) begin
            ld_idx_q <= (ld_idx_q == LAST) ? '0 : ld_idx_q + ONE;
          end else if (start) begin
            state_q  <= MULT;
            busy_q   <= 1'b1;
            ld_idx_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
          end
        end
        MULT: begin
          if (i_q == LAST) begin
            i_q <= '0;
            if (j_q == LAST) begin
              j_q     <= '0;
              k_q     <= '0;
              state_q <= OUT;
            end else begin
              j_q <= j_q + ONE;
            end
          end else begin
            i_q <= i_q + ONE;
          end
        end
        OUT: begin
          // two-stage stream: registered RAM read, then registered output sum
          if (!k_q[IW]) begin
            rd1_q <= acc1_mem[k_q[IW-1:0]];
            rd2_q <= acc2_mem[k_q[IW-1:0]];
            e2r_q <= e2_mem[k_q[IW-1:0]];
            e3r_q <= e3_mem[k_q[IW-1:0]];
            mr_q  <= m_mem[k_q[IW-1:0]];
            rv_q  <= 1'b1;
          end else begin
            rv_q <= 1'b0;
          end
          valid_q <= rv_q;
          if (rv_q) begin
            c1_q <= rd1_q + {{(W-1){1'b0}}, e2r_q};
            c2_q <= rd2_q + {{(W-1){1'b0}}, e3r_q} + (mr_q ? SCALE : '0);
          end
          if (k_q == K_END) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            k_q <= k_q + K_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c1_out = c1_q;
  assign c2_out = c2_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule
